// File: rtl/vga_timing_pkg.sv
// Shared constants, FSM state encoding and colour-bar table for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_D = 640;
  localparam int unsigned H_FP_D     = 16;
  localparam int unsigned H_SYNC_D   = 96;
  localparam int unsigned H_BP_D     = 48;
  localparam int unsigned V_ACTIVE_D = 480;
  localparam int unsigned V_FP_D     = 10;
  localparam int unsigned V_SYNC_D   = 2;
  localparam int unsigned V_BP_D     = 33;
  localparam int unsigned CW_D       = 10;

  localparam int unsigned H_TOTAL = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int unsigned V_TOTAL = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int unsigned RGB_W = 24;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vga_state_t;

  // Eight vertical bars, left to right.
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    c = 24'h000000;
    case (idx)
      3'd0: c = 24'hFFFFFF;
      3'd1: c = 24'hFFFF00;
      3'd2: c = 24'h00FFFF;
      3'd3: c = 24'h00FF00;
      3'd4: c = 24'hFF00FF;
      3'd5: c = 24'hFF0000;
      3'd6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator (hsync/vsync/de/coordinates) gated by PLL lock.
// Optional colour-bar output enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_D,
  parameter int unsigned H_FP      = H_FP_D,
  parameter int unsigned H_SYNC    = H_SYNC_D,
  parameter int unsigned H_BP      = H_BP_D,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_D,
  parameter int unsigned V_FP      = V_FP_D,
  parameter int unsigned V_SYNC    = V_SYNC_D,
  parameter int unsigned V_BP      = V_BP_D,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CW        = CW_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
`ifdef VGA_TEST_PATTERN_EN
  , output logic [RGB_W-1:0] rgb
`endif
);

  localparam int unsigned HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  vga_state_t    state;
  logic          lock_s;
  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] cur_h, cur_v;
  logic          h_last, v_last, de_c, hs_act_c, vs_act_c;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Raster position emitted on the next edge; a fresh RUN always starts at (0,0).
  always_comb begin
    cur_h    = (state == RUN) ? h_cnt : '0;
    cur_v    = (state == RUN) ? v_cnt : '0;
    h_last   = (cur_h == CW'(HT - 1));
    v_last   = (cur_v == CW'(VT - 1));
    de_c     = (cur_h < CW'(H_ACTIVE)) && (cur_v < CW'(V_ACTIVE));
    hs_act_c = (cur_h >= CW'(H_ACTIVE + H_FP)) && (cur_h < CW'(H_ACTIVE + H_FP + H_SYNC));
    vs_act_c = (cur_v >= CW'(V_ACTIVE + V_FP)) && (cur_v < CW'(V_ACTIVE + V_FP + V_SYNC));
  end

  // IDLE/RUN FSM with counters and registered video outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      rgb         <= '0;
`endif
    end else if (lock_s) begin
      state       <= RUN;
      h_cnt       <= h_last ? '0 : cur_h + CW'(1);
      v_cnt       <= h_last ? (v_last ? '0 : cur_v + CW'(1)) : cur_v;
      hsync       <= hs_act_c ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_act_c ? VSYNC_POL : ~VSYNC_POL;
      de          <= de_c;
      x           <= de_c ? cur_h : '0;
      y           <= de_c ? cur_v : '0;
      line_start  <= de_c && (cur_h == '0);
      frame_start <= de_c && (cur_h == '0) && (cur_v == '0);
      running     <= 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      rgb         <= de_c ? bar_colour(3'(cur_h / CW'(BAR_W))) : '0;
`endif
    end else begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      rgb         <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: pixel-index reference model plus directed checks.
// Uses full horizontal timing and a shortened vertical frame to keep runtime small.
module tb_vga_timing_gen;

  localparam int H_TOT = 800;
  localparam int V_ACT = 6;
  localparam int V_FPB = 2;
  localparam int V_SYN = 2;
  localparam int V_BPB = 3;
  localparam int V_TOT = V_ACT + V_FPB + V_SYN + V_BPB;
  localparam int FRAME = H_TOT * V_TOT;

  logic       clk = 1'b0;
  bit         clk_en = 1'b1;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       hsync, vsync, de, line_start, frame_start, running;
  logic [9:0] x, y;
`ifdef VGA_TEST_PATTERN_EN
  logic [23:0] rgb;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #10 if (clk_en) clk = ~clk;

  vga_timing_gen #(
    .V_ACTIVE (V_ACT),
    .V_FP     (V_FPB),
    .V_SYNC   (V_SYN),
    .V_BP     (V_BPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .running     (running)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb       (rgb)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel index within the frame; output is due two edges after lock is seen.
  logic [1:0] m_hist = 2'b00;
  bit         m_run = 1'b0;
  int         m_p = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist <= 2'b00;
      m_run  <= 1'b0;
      m_p    <= 0;
    end else begin
      m_hist <= {m_hist[0], pll_locked};
      if (m_hist[1]) begin
        m_p   <= m_run ? (m_p + 1) % FRAME : 0;
        m_run <= 1'b1;
      end else begin
        m_p   <= 0;
        m_run <= 1'b0;
      end
    end
  end

  function automatic logic [26:0] model_out(input bit run, input int p);
    int h, v;
    bit d, hs, vs;
    h  = p % H_TOT;
    v  = p / H_TOT;
    d  = run && (h < 640) && (v < V_ACT);
    hs = !(run && h >= 656 && h < 752);
    vs = !(run && v >= V_ACT + V_FPB && v < V_ACT + V_FPB + V_SYN);
    return {hs, vs, d, d ? 10'(h) : 10'd0, d ? 10'(v) : 10'd0,
            d && h == 0, d && h == 0 && v == 0, run};
  endfunction

  logic [26:0] dut_vec;
  assign dut_vec = {hsync, vsync, de, x, y, line_start, frame_start, running};

  // Cycle-by-cycle comparison against the model, sampled mid-period.
  always @(negedge clk) begin
    chk("cycle", 32'(dut_vec), 32'(model_out(m_run, m_p)));
`ifdef VGA_TEST_PATTERN_EN
    chk("rgb_cycle", 32'(rgb),
        32'((m_run && (m_p % H_TOT) < 640 && (m_p / H_TOT) < V_ACT) ? bars[(m_p % H_TOT) / 80] : 24'h0));
`endif
  end

  initial begin
    bit ok;
    int first_hs, hs_cnt, de_cnt, period, vs_cnt, ls_cnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_running", running, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_running", running, 0);

    // Lock: outputs start on the third edge
    pll_locked = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("lock_e2_de", de, 0);
    @(posedge clk); #1;
    chk("lock_e3_de", de, 1);
    chk("lock_e3_x", x, 0);
    chk("lock_e3_y", y, 0);
    chk("lock_e3_fs", frame_start, 1);
    chk("lock_e3_ls", line_start, 1);
    chk("lock_e3_run", running, 1);

    // One line: hsync placement/width, de width, line period
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); ok = line_start; end
    chk("wait_line_start", ok, 1);
    first_hs = -1; hs_cnt = 0; de_cnt = 0;
    for (int i = 0; i < H_TOT; i++) begin
      if (i > 0) @(negedge clk);
      if (!hsync) begin hs_cnt++; if (first_hs < 0) first_hs = i; end
      if (de) de_cnt++;
`ifdef VGA_TEST_PATTERN_EN
      if (i == 0)   chk("rgb_x0", rgb, 24'hFFFFFF);
      if (i == 80)  chk("rgb_x80", rgb, 24'hFFFF00);
      if (i == 639) chk("rgb_x639", rgb, 24'h000000);
      if (i == 700) chk("rgb_blank", rgb, 24'h0);
`endif
    end
    chk("hsync_first", 32'(first_hs), 656);
    chk("hsync_width", 32'(hs_cnt), 96);
    chk("de_width", 32'(de_cnt), 640);
    @(negedge clk);
    chk("line_period", line_start, 1);

    // One frame: period, vsync lines, line count
    ok = 0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin @(negedge clk); ok = frame_start; end
    chk("wait_frame_start", ok, 1);
    period = 0; vs_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (!vsync) vs_cnt++;
      if (line_start) ls_cnt++;
      @(negedge clk);
      period++;
      if (frame_start) break;
    end
    chk("frame_period", 32'(period), 32'(FRAME));
    chk("vsync_cycles", 32'(vs_cnt), 1600);
    chk("lines_per_frame", 32'(ls_cnt), 6);

    // Lock loss at (300,3), then relock
    ok = 0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin @(negedge clk); ok = (x == 300 && y == 3); end
    chk("wait_x300", ok, 1);
    pll_locked = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("drop_e2_run", running, 1);
    @(posedge clk); #1;
    chk("drop_e3_de", de, 0);
    chk("drop_e3_hs", hsync, 1);
    chk("drop_e3_vs", vsync, 1);
    chk("drop_e3_run", running, 0);
    pll_locked = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("relock_de", de, 1);
    chk("relock_x", x, 0);
    chk("relock_y", y, 0);
    chk("relock_fs", frame_start, 1);

    // Asynchronous reset with the clock stopped
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); ok = (x == 100); end
    chk("wait_x100", ok, 1);
    clk_en = 1'b0;
    #5 rst = 1'b1;
    #1;
    chk("arst_hs", hsync, 1);
    chk("arst_vs", vsync, 1);
    chk("arst_de", de, 0);
    chk("arst_x", x, 0);
    chk("arst_run", running, 0);
    #5 rst = 1'b0;
    #9 clk_en = 1'b1;

    // Randomised lock toggling and occasional asynchronous resets
    for (int it = 0; it < 30; it++) begin
      pll_locked = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 1500)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        #5 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
